// File: rtl/traffic_controller_timed.sv
// Highway/country intersection controller with configurable phase timing, highway minimum
// green, country maximum green and a latched pedestrian walk phase.
module traffic_controller_timed #(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned Y2R_DELAY     = 3,
    parameter int unsigned R2G_DELAY     = 2,
    parameter int unsigned HWY_MIN_GREEN = 8,
    parameter int unsigned CNTRY_MAX_GRN = 10,
    parameter int unsigned PED_TIME      = 6
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       ped_walk,
    output logic [2:0] state_o
);

    localparam logic [1:0] LampRed    = 2'd0;
    localparam logic [1:0] LampYellow = 2'd1;
    localparam logic [1:0] LampGreen  = 2'd2;

    localparam int unsigned MaxDelay =
        (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

    // Last timer value of each phase: a phase of N cycles exits when timer == N-1.
    localparam logic [CNT_W-1:0] Y2rLast      = CNT_W'(Y2R_DELAY - 1);
    localparam logic [CNT_W-1:0] R2gLast      = CNT_W'(R2G_DELAY - 1);
    localparam logic [CNT_W-1:0] HwyMinLast   = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CntryMaxLast = CNT_W'(CNTRY_MAX_GRN - 1);
    localparam logic [CNT_W-1:0] PedLast      = CNT_W'(PED_TIME - 1);

    if (Y2R_DELAY < 1 || Y2R_DELAY > MaxDelay ||
        R2G_DELAY < 1 || R2G_DELAY > MaxDelay ||
        HWY_MIN_GREEN < 1 || HWY_MIN_GREEN > MaxDelay ||
        CNTRY_MAX_GRN < 1 || CNTRY_MAX_GRN > MaxDelay ||
        PED_TIME < 1 || PED_TIME > MaxDelay) begin : g_bad_delay
        $error("traffic_controller_timed: every delay must lie in 1..2**CNT_W-1");
    end

    typedef enum logic [2:0] {
        StHwyGreen    = 3'd0,
        StHwyYellow   = 3'd1,
        StAllRed      = 3'd2,
        StCntryGreen  = 3'd3,
        StCntryYellow = 3'd4,
        StPedWalk     = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pend_q, ped_pend_d;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= StHwyGreen;
            timer_q    <= '0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHwyGreen: begin
                if (timer_q >= HwyMinLast && (x || ped_pend_q)) begin
                    state_d = StHwyYellow;
                end
            end
            StHwyYellow: begin
                if (timer_q == Y2rLast) begin
                    state_d = StAllRed;
                end
            end
            StAllRed: begin
                if (timer_q == R2gLast) begin
                    state_d = ped_pend_q ? StPedWalk : StCntryGreen;
                end
            end
            StCntryGreen: begin
                if (!x || timer_q == CntryMaxLast) begin
                    state_d = StCntryYellow;
                end
            end
            StCntryYellow: begin
                if (timer_q == Y2rLast) begin
                    state_d = StHwyGreen;
                end
            end
            StPedWalk: begin
                if (timer_q == PedLast) begin
                    state_d = x ? StCntryGreen : StHwyGreen;
                end
            end
            default: state_d = StHwyGreen;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Requests made during the walk, or on its entry edge, are served by that walk.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (state_d == StPedWalk) begin
            ped_pend_d = 1'b0;
        end else if (state_q != StPedWalk && ped_req) begin
            ped_pend_d = 1'b1;
        end
    end

    always_comb begin
        hwy      = LampRed;
        cntry    = LampRed;
        ped_walk = 1'b0;
        case (state_q)
            StHwyGreen:    hwy      = LampGreen;
            StHwyYellow:   hwy      = LampYellow;
            StCntryGreen:  cntry    = LampGreen;
            StCntryYellow: cntry    = LampYellow;
            StPedWalk:     ped_walk = 1'b1;
            default:       ;
        endcase
    end

    assign state_o = state_q;

    a_lamps_exclusive : assert property (@(posedge clock) disable iff (!clear)
        !(hwy != LampRed && cntry != LampRed));

endmodule

// File: tb/tb_traffic_controller_timed.sv
// Directed bench for traffic_controller_timed: per-scenario expected-state tables checked
// every cycle, plus hand-written asynchronous-reset sequences.
module tb_traffic_controller_timed;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       x = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       ped_walk;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_controller_timed dut (
        .clock   (clock),
        .clear   (clear),
        .x       (x),
        .ped_req (ped_req),
        .hwy     (hwy),
        .cntry   (cntry),
        .ped_walk(ped_walk),
        .state_o (state_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         scen;
        int         lo;
        int         hi;
        logic [2:0] st;
    } seg_t;

    seg_t segs[$];

    // Lamp decode from the state table: {hwy, cntry, ped_walk}.
    function automatic logic [4:0] lamps(input logic [2:0] st);
        case (st)
            3'd0:    return {2'd2, 2'd0, 1'b0};
            3'd1:    return {2'd1, 2'd0, 1'b0};
            3'd2:    return {2'd0, 2'd0, 1'b0};
            3'd3:    return {2'd0, 2'd2, 1'b0};
            3'd4:    return {2'd0, 2'd1, 1'b0};
            3'd5:    return {2'd0, 2'd0, 1'b1};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic scen_x(input int s, input int c);
        case (s)
            2:       return 1'b1;
            3:       return (c >= 2 && c <= 4);
            5:       return (c <= 16);
            7:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic scen_ped(input int s, input int c);
        case (s)
            4:       return (c == 2 || c == 12 || c == 15);
            7:       return (c == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input int cyc, input logic [2:0] st);
        logic [7:0] act;
        logic [7:0] exp;
        act = {state_o, hwy, cntry, ped_walk};
        exp = {st, lamps(st)};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got state=%0d hwy=%0d cntry=%0d walk=%0b, expected state=%0d hwy=%0d cntry=%0d walk=%0b",
                     name, cyc, act[7:5], act[4:3], act[2:1], act[0],
                     exp[7:5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    // Holds clear low with busy inputs, then releases it on a falling edge; the next rising
    // edge is cycle 0.
    task automatic apply_reset();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            x       = 1'b1;
            ped_req = i[0];
            check("reset_hold", i, 3'd0);
        end
        @(negedge clock);
        x       = 1'b0;
        ped_req = 1'b0;
        clear   = 1'b1;
    endtask

    task automatic drive_cycle(input string name, input int c, input logic xv,
                               input logic pv, input logic [2:0] st);
        x       = xv;
        ped_req = pv;
        check(name, c, st);
        @(negedge clock);
    endtask

    // Reset between clock edges, away from any rising edge.
    task automatic async_reset(input string name);
        #2;
        clear = 1'b0;
        #1;
        check(name, -1, 3'd0);
        @(negedge clock);
        x       = 1'b0;
        ped_req = 1'b0;
        clear   = 1'b1;
    endtask

    initial begin
        int scens[5] = '{2, 3, 4, 5, 7};

        segs.push_back('{2, 0, 7, 3'd0});
        segs.push_back('{2, 8, 10, 3'd1});
        segs.push_back('{2, 11, 12, 3'd2});
        segs.push_back('{2, 13, 22, 3'd3});
        segs.push_back('{2, 23, 25, 3'd4});
        segs.push_back('{2, 26, 33, 3'd0});
        segs.push_back('{2, 34, 36, 3'd1});
        segs.push_back('{2, 37, 38, 3'd2});
        segs.push_back('{2, 39, 39, 3'd3});
        segs.push_back('{3, 0, 299, 3'd0});
        segs.push_back('{4, 0, 7, 3'd0});
        segs.push_back('{4, 8, 10, 3'd1});
        segs.push_back('{4, 11, 12, 3'd2});
        segs.push_back('{4, 13, 18, 3'd5});
        segs.push_back('{4, 19, 45, 3'd0});
        segs.push_back('{5, 0, 7, 3'd0});
        segs.push_back('{5, 8, 10, 3'd1});
        segs.push_back('{5, 11, 12, 3'd2});
        segs.push_back('{5, 13, 17, 3'd3});
        segs.push_back('{5, 18, 20, 3'd4});
        segs.push_back('{5, 21, 30, 3'd0});
        segs.push_back('{7, 0, 7, 3'd0});
        segs.push_back('{7, 8, 10, 3'd1});
        segs.push_back('{7, 11, 12, 3'd2});
        segs.push_back('{7, 13, 18, 3'd5});
        segs.push_back('{7, 19, 28, 3'd3});
        segs.push_back('{7, 29, 31, 3'd4});
        segs.push_back('{7, 32, 39, 3'd0});
        segs.push_back('{7, 40, 40, 3'd1});

        foreach (scens[k]) begin
            int s;
            int ncyc;
            s    = scens[k];
            ncyc = 0;
            foreach (segs[j]) begin
                if (segs[j].scen == s && segs[j].hi + 1 > ncyc) ncyc = segs[j].hi + 1;
            end
            apply_reset();
            for (int c = 0; c < ncyc; c++) begin
                logic [2:0] st;
                st = 3'd0;
                foreach (segs[j]) begin
                    if (segs[j].scen == s && c >= segs[j].lo && c <= segs[j].hi) st = segs[j].st;
                end
                drive_cycle($sformatf("scen%0d", s), c, scen_x(s, c), scen_ped(s, c), st);
            end
        end

        // Clear mid country green, then the controller restarts in highway green.
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            drive_cycle("pre_s3", c, 1'b1, 1'b0,
                        (c < 8) ? 3'd0 : (c < 11) ? 3'd1 : (c < 13) ? 3'd2 : 3'd3);
        end
        check("in_s3", 15, 3'd3);
        async_reset("async_s3");
        for (int c = 0; c < 10; c++) drive_cycle("post_s3", c, 1'b0, 1'b0, 3'd0);

        // Clear mid pedestrian walk.
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            drive_cycle("pre_s5", c, 1'b0, (c == 2),
                        (c < 8) ? 3'd0 : (c < 11) ? 3'd1 : (c < 13) ? 3'd2 : 3'd5);
        end
        check("in_s5", 15, 3'd5);
        async_reset("async_s5");
        for (int c = 0; c < 10; c++) drive_cycle("post_s5", c, 1'b0, 1'b0, 3'd0);

        // A pending request must not survive a reset.
        apply_reset();
        for (int c = 0; c < 4; c++) drive_cycle("pend_set", c, 1'b0, (c == 2), 3'd0);
        async_reset("async_pend");
        for (int c = 0; c < 15; c++) drive_cycle("pend_discard", c, 1'b0, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
